// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC expansion-bus initiator: op codes, T-state
// encoding and the strobe pattern driven in each (op, T-state) pair.
// Optional feature macro: CPC_BUS_REFRESH_EN (M1 refresh cycles and R counter).
package cpc_bus_pkg;

  localparam logic [1:0] OP_MRD  = 2'b00;
  localparam logic [1:0] OP_MWR  = 2'b01;
  localparam logic [1:0] OP_IOWR = 2'b10;
  localparam logic [1:0] OP_M1   = 2'b11;

`ifdef CPC_BUS_REFRESH_EN
  localparam bit REFRESH_EN = 1'b1;
`else
  localparam bit REFRESH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } state_e;

  // Bus strobes are active low; data_oe is active high.
  typedef struct packed {
    logic mreq_b;
    logic iorq_b;
    logic rd_b;
    logic wr_b;
    logic m1_b;
    logic rfsh_b;
    logic data_oe;
  } strobe_t;

  //                                     mreq iorq rd wr m1 rfsh oe
  localparam strobe_t STB_IDLE    = 7'b1____1____1__1__1__1____0;
  localparam strobe_t STB_MRD     = 7'b0____1____0__1__1__1____0;
  localparam strobe_t STB_MWR_T1  = 7'b0____1____1__1__1__1____1;
  localparam strobe_t STB_MWR     = 7'b0____1____1__0__1__1____1;
  localparam strobe_t STB_IOWR_T1 = 7'b1____1____1__1__1__1____1;
  localparam strobe_t STB_IOWR    = 7'b1____0____1__0__1__1____1;
  localparam strobe_t STB_M1      = 7'b0____1____0__1__0__1____0;
  localparam strobe_t STB_RFSH    = 7'b0____1____1__1__1__0____0;

  // Strobe pattern to present while the bus sits in state st for operation op.
  function automatic strobe_t strobes_for(input logic [1:0] op, input state_e st);
    strobe_t s;
    s = STB_IDLE;
    case (st)
      ST_T1: begin
        case (op)
          OP_MRD:  s = STB_MRD;
          OP_MWR:  s = STB_MWR_T1;
          OP_IOWR: s = STB_IOWR_T1;
          default: s = STB_M1;
        endcase
      end
      ST_T2, ST_TW: begin
        case (op)
          OP_MRD:  s = STB_MRD;
          OP_MWR:  s = STB_MWR;
          OP_IOWR: s = STB_IOWR;
          default: s = STB_M1;
        endcase
      end
      ST_T3: begin
        case (op)
          OP_MRD:  s = STB_MRD;
          OP_MWR:  s = STB_MWR;
          OP_IOWR: s = STB_IOWR;
          default: s = REFRESH_EN ? STB_RFSH : STB_M1;
        endcase
      end
      ST_T4:   s = STB_RFSH;
      default: s = STB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpc_bus_wait_ctr.sv
// Wait-state counter: cleared when a cycle enters T1, counts each counted TW.
// Latency: registered count, timeout_o valid the cycle after the TW entry.
// Backpressure: none; counter saturates at 255.
// Ports: clk, reset_b (sync, active low), clr_i, inc_i, timeout_o (count >= MAX_WAIT).
module cpc_bus_wait_ctr
  import cpc_bus_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // In TW the count equals the number of counted TWs including the current one.
  assign timeout_o = (cnt_q >= 8'(MAX_WAIT));

endmodule

// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus master, one T-state per clk: MRD, MWR, IOWR, M1 fetch.
// Latency accept->rsp_valid: MRD/MWR 4, IOWR 5, M1 5 (4 without refresh), plus TWs.
// Backpressure: req_ready only in IDLE; bus ready=0 inserts TWs, MAX_WAIT TWs abort.
// Ports: req_* request handshake, rsp_* one-cycle completion, adr/data_*/strobes bus side,
// ready wait input. Macro CPC_BUS_REFRESH_EN enables M1 refresh (T3/T4) and R counter.
module cpc_bus_initiator
  import cpc_bus_pkg::*;
#(
  parameter int         MAX_WAIT = 16,
  parameter logic [7:0] I_REG    = 8'h00
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        m1_b,
  output logic        rfsh_b,
  input  logic        ready
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] areq_q, areq_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  strobe_t     stb_q;
  logic        req_rdy_q;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        timeout;
  logic        wait_clr, wait_inc;
  logic [6:0]  r_cur;

`ifdef CPC_BUS_REFRESH_EN
  // Refresh counter: bit 7 of R is never driven, low 7 bits wrap.
  logic [6:0] r_q;
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_q <= 7'd0;
    end else if (state_q == ST_T4) begin
      r_q <= r_q + 7'd1;
    end
  end
  assign r_cur = r_q;
`else
  assign r_cur = 7'd0;
`endif

  // The automatic IOWR wait (T2->TW) is not a counted wait state.
  assign wait_clr = (state_d == ST_T1);
  assign wait_inc = (state_d == ST_TW) && !(state_q == ST_T2 && op_q == OP_IOWR);

  cpc_bus_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .clk       (clk),
    .reset_b   (reset_b),
    .clr_i     (wait_clr),
    .inc_i     (wait_inc),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    areq_d      = areq_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_T1;
          op_d    = req_op;
          areq_d  = req_adr;
          dout_d  = req_wdata;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        if (op_q == OP_IOWR || !ready) begin
          state_d = ST_TW;
        end else begin
          state_d = ST_T3;
        end
      end
      ST_TW: begin
        if (ready) begin
          state_d = ST_T3;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end
      end
      ST_T3: begin
        if (REFRESH_EN && op_q == OP_M1) begin
          state_d = ST_T4;
        end else begin
          state_d     = ST_IDLE;
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = (op_q == OP_MRD || op_q == OP_M1) ? data_in : 8'h00;
        end
      end
      ST_T4: begin
        state_d     = ST_IDLE;
        rsp_vld_d   = 1'b1;
        rsp_rdata_d = rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Refreshing M1 latches its opcode as the bus leaves the read phase.
    if ((state_q == ST_T2 || state_q == ST_TW) && state_d == ST_T3) begin
      rdata_d = data_in;
    end

    // Refresh address overrides during T3/T4; otherwise the request address
    // is held, including in IDLE, so adr never glitches between cycles.
    if (REFRESH_EN && op_d == OP_M1 && (state_d == ST_T3 || state_d == ST_T4)) begin
      adr_d = {I_REG, 1'b0, r_cur};
    end else begin
      adr_d = areq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MRD;
      areq_q      <= 16'h0000;
      adr_q       <= 16'h0000;
      dout_q      <= 8'h00;
      rdata_q     <= 8'h00;
      stb_q       <= STB_IDLE;
      req_rdy_q   <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      areq_q      <= areq_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      stb_q       <= strobes_for(op_d, state_d);
      req_rdy_q   <= (state_d == ST_IDLE);
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_rdy_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign adr       = adr_q;
  assign data_out  = dout_q;
  assign data_oe   = stb_q.data_oe;
  assign mreq_b    = stb_q.mreq_b;
  assign iorq_b    = stb_q.iorq_b;
  assign rd_b      = stb_q.rd_b;
  assign wr_b      = stb_q.wr_b;
  assign m1_b      = stb_q.m1_b;
  assign rfsh_b    = stb_q.rfsh_b;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: reset, IOWR, MRD with waits, MWR timeout,
// reset mid-cycle and M1 fetches (refresh or plain depending on CPC_BUS_REFRESH_EN).
module tb_cpc_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_adr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] adr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
  logic        ready;
  logic [5:0]  stb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b}
  assign stb = {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b};

  cpc_bus_initiator #(.MAX_WAIT(16), .I_REG(8'h00)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .adr       (adr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in),
    .mreq_b    (mreq_b),
    .iorq_b    (iorq_b),
    .rd_b      (rd_b),
    .wr_b      (wr_b),
    .m1_b      (m1_b),
    .rfsh_b    (rfsh_b),
    .ready     (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_b   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_adr   = 16'h0000;
    req_wdata = 8'h00;
    data_in   = 8'h00;
    ready     = 1'b1;

    // ---------------- reset state
    tick();
    tick();
    chk("rst_stb",   32'(stb), 32'h3F);
    chk("rst_adr",   32'(adr), 32'h0);
    chk("rst_oe",    32'(data_oe), 32'h0);
    chk("rst_dout",  32'(data_out), 32'h0);
    chk("rst_rsp",   32'({rsp_valid, rsp_err, rsp_rdata}), 32'h0);
    reset_b = 1'b1;
    tick();
    chk("rst_rdy",   32'(req_ready), 32'h1);

    // ---------------- IOWR 0x7F00 <- 0xC4, no waits: T1 T2 TW T3, rsp at 5
    req_valid = 1'b1; req_op = 2'b10; req_adr = 16'h7F00; req_wdata = 8'hC4;
    tick();
    req_valid = 1'b0; req_adr = 16'h0000; req_wdata = 8'h00;
    chk("iowr_t1_stb",  32'(stb), 32'h3F);
    chk("iowr_t1_oe",   32'(data_oe), 32'h1);
    chk("iowr_t1_rdy",  32'(req_ready), 32'h0);
    chk("iowr_t1_adr",  32'(adr), 32'h7F00);
    chk("iowr_t1_dout", 32'(data_out), 32'hC4);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("iowr_busy_stb",  32'(stb), 32'h2B);
      chk("iowr_busy_vld",  32'(rsp_valid), 32'h0);
      chk("iowr_busy_dout", 32'(data_out), 32'hC4);
      chk("iowr_busy_adr",  32'(adr), 32'h7F00);
    end
    tick();
    chk("iowr_rsp_vld", 32'(rsp_valid), 32'h1);
    chk("iowr_rsp_err", 32'(rsp_err), 32'h0);
    chk("iowr_rsp_dat", 32'(rsp_rdata), 32'h0);
    chk("iowr_end_stb", 32'(stb), 32'h3F);
    chk("iowr_end_oe",  32'(data_oe), 32'h0);
    chk("iowr_end_rdy", 32'(req_ready), 32'h1);
    tick();
    chk("iowr_pulse",   32'(rsp_valid), 32'h0);

    // ---------------- MRD 0xC000 with two wait states
    data_in = 8'h33;
    req_valid = 1'b1; req_op = 2'b00; req_adr = 16'hC000;
    tick();                                  // T1
    req_valid = 1'b0; req_adr = 16'h0000;
    chk("mrd_t1_stb", 32'(stb), 32'h17);
    chk("mrd_t1_adr", 32'(adr), 32'hC000);
    chk("mrd_t1_oe",  32'(data_oe), 32'h0);
    tick();                                  // T2
    ready = 1'b0;
    tick();                                  // TW1
    chk("mrd_tw1_stb", 32'(stb), 32'h17);
    chk("mrd_tw1_vld", 32'(rsp_valid), 32'h0);
    tick();                                  // TW2
    ready = 1'b1;
    chk("mrd_tw2_stb", 32'(stb), 32'h17);
    tick();                                  // T3
    data_in = 8'h5A;
    chk("mrd_t3_stb", 32'(stb), 32'h17);
    chk("mrd_t3_vld", 32'(rsp_valid), 32'h0);
    tick();                                  // IDLE + rsp
    data_in = 8'h33;
    chk("mrd_rsp_vld", 32'(rsp_valid), 32'h1);
    chk("mrd_rsp_dat", 32'(rsp_rdata), 32'h5A);
    chk("mrd_rsp_err", 32'(rsp_err), 32'h0);
    chk("mrd_end_stb", 32'(stb), 32'h3F);
    chk("mrd_end_adr", 32'(adr), 32'hC000);

    // ---------------- MWR with ready stuck low: 16 TWs then abort
    ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_adr = 16'h1234; req_wdata = 8'h99;
    tick();                                  // T1
    req_valid = 1'b0;
    chk("mwr_t1_stb",  32'(stb), 32'h1F);
    chk("mwr_t1_oe",   32'(data_oe), 32'h1);
    chk("mwr_t1_dout", 32'(data_out), 32'h99);
    tick();                                  // T2
    chk("mwr_t2_stb",  32'(stb), 32'h1B);
    for (int k = 1; k <= 16; k++) begin
      tick();                                // TW k
      chk("mwr_tw_stb", 32'(stb), 32'h1B);
      chk("mwr_tw_vld", 32'(rsp_valid), 32'h0);
    end
    tick();
    chk("mwr_to_vld", 32'(rsp_valid), 32'h1);
    chk("mwr_to_err", 32'(rsp_err), 32'h1);
    chk("mwr_to_dat", 32'(rsp_rdata), 32'h0);
    chk("mwr_to_stb", 32'(stb), 32'h3F);
    chk("mwr_to_oe",  32'(data_oe), 32'h0);
    tick();
    chk("mwr_to_pulse", 32'(rsp_valid), 32'h0);
    chk("mwr_to_errclr", 32'(rsp_err), 32'h0);

    // ---------------- reset asserted during a TW of MWR
    req_valid = 1'b1; req_op = 2'b01; req_adr = 16'h4000; req_wdata = 8'h11;
    tick();                                  // T1
    req_valid = 1'b0;
    tick();                                  // T2
    tick();                                  // TW
    chk("rmid_tw_stb", 32'(stb), 32'h1B);
    reset_b = 1'b0;
    tick();
    chk("rmid_stb", 32'(stb), 32'h3F);
    chk("rmid_oe",  32'(data_oe), 32'h0);
    chk("rmid_vld", 32'(rsp_valid), 32'h0);
    reset_b = 1'b1;
    ready   = 1'b1;
    tick();
    chk("rmid_rdy",  32'(req_ready), 32'h1);
    chk("rmid_vld2", 32'(rsp_valid), 32'h0);
    tick();
    chk("rmid_vld3", 32'(rsp_valid), 32'h0);
    chk("rmid_stb3", 32'(stb), 32'h3F);

`ifdef CPC_BUS_REFRESH_EN
    // ---------------- 129 back-to-back M1 fetches with refresh
    req_op = 2'b11;
    for (int i = 0; i < 129; i++) begin
      req_valid = 1'b1;
      req_adr   = 16'h8000 + 16'(i);
      tick();                                // T1
      req_valid = (i != 128);
      req_adr   = 16'hFFFF;
      chk("m1_t1_stb", 32'(stb), 32'h15);
      chk("m1_t1_adr", 32'(adr), 32'h8000 + 32'(i));
      tick();                                // T2
      data_in = 8'(i) ^ 8'hA5;
      chk("m1_t2_stb", 32'(stb), 32'h15);
      tick();                                // T3
      data_in = 8'h00;
      chk("m1_t3_stb", 32'(stb), 32'h1E);
      chk("m1_t3_adr", 32'(adr), 32'(i % 128));
      tick();                                // T4
      chk("m1_t4_stb", 32'(stb), 32'h1E);
      chk("m1_t4_adr", 32'(adr), 32'(i % 128));
      chk("m1_t4_vld", 32'(rsp_valid), 32'h0);
      tick();                                // IDLE + rsp
      chk("m1_rsp_vld", 32'(rsp_valid), 32'h1);
      chk("m1_rsp_dat", 32'(rsp_rdata), 32'(8'(i) ^ 8'hA5));
      chk("m1_rsp_err", 32'(rsp_err), 32'h0);
      chk("m1_rsp_rdy", 32'(req_ready), 32'h1);
    end
    tick();
    chk("m1_last_pulse", 32'(rsp_valid), 32'h0);
`else
    // ---------------- M1 without refresh: 3 T-states, rfsh_b never asserted
    req_op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_adr   = 16'h0100 + 16'(i);
      tick();                                // T1
      req_valid = 1'b0;
      chk("m1n_t1_stb", 32'(stb), 32'h15);
      chk("m1n_t1_adr", 32'(adr), 32'h0100 + 32'(i));
      tick();                                // T2
      chk("m1n_t2_stb", 32'(stb), 32'h15);
      tick();                                // T3
      data_in = 8'(i) + 8'h61;
      chk("m1n_t3_stb", 32'(stb), 32'h15);
      chk("m1n_t3_vld", 32'(rsp_valid), 32'h0);
      tick();                                // IDLE + rsp
      data_in = 8'h00;
      chk("m1n_rsp_vld", 32'(rsp_valid), 32'h1);
      chk("m1n_rsp_dat", 32'(rsp_rdata), 32'(8'(i) + 8'h61));
      chk("m1n_end_stb", 32'(stb), 32'h3F);
    end
    tick();
    chk("m1n_last_pulse", 32'(rsp_valid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
